writeback_arbiter: RTL and testbench

Final writeback stage directly upstream of the register file: merges the single-cycle ALU result path and the variable-latency load return path into the one `reg_write_control_t` write port. Load data is byte/half/word-extracted and sign/zero-extended here, buffered in a small FIFO, and drained whenever the ALU path is idle. A per-register pending-load mask is exported for the issue-stage scoreboard.

---
 rtl/writeback_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_writeback_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: final writeback stage ahead of the register file.
// Merges the single-cycle ALU result path with the variable-latency load
// return path onto one registered register-file write port. Load data is
// extracted and extended here, queued in a small FIFO, and drained on
// cycles where the ALU path is idle.
//
// Ports:
//   clock, reset          rising-edge clock, async active-low reset
//   alu_wb_valid/rd/value ALU result (never stalled, absolute priority)
//   load_valid/ready      load return handshake
//   load_rd/funct3        load destination and RV32I load type
//   load_addr_lo/word     address bits [1:0] and raw aligned word
//   write_control         registered register-file write {enable, rd, value}
//   pending_mask          bit r set while a load to xr is queued
//   load_error            one-cycle pulse for a dropped bad/misaligned load

package writeback_arbiter_pkg;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] rv_reg_t;

  typedef struct packed {
    logic            enable;
    rv_reg_t         which_register;
    logic [XLEN-1:0] value;
  } reg_write_control_t;
endpackage

module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned LOAD_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               alu_wb_valid,
  input  rv_reg_t            alu_wb_rd,
  input  logic [XLEN-1:0]    alu_wb_value,
  input  logic               load_valid,
  output logic               load_ready,
  input  rv_reg_t            load_rd,
  input  logic [2:0]         load_funct3,
  input  logic [1:0]         load_addr_lo,
  input  logic [31:0]        load_word,
  output reg_write_control_t write_control,
  output logic [31:0]        pending_mask,
  output logic               load_error
);

  localparam int unsigned PTR_W = $clog2(LOAD_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LOAD_DEPTH);

  // FIFO storage and bookkeeping
  rv_reg_t            r_ent_rd  [LOAD_DEPTH];
  logic [XLEN-1:0]    r_ent_val [LOAD_DEPTH];
  logic               r_ent_vld [LOAD_DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  // Registered outputs
  reg_write_control_t r_wc;
  logic               r_load_ready;
  logic               r_load_error;

  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [XLEN-1:0]    w_ext;
  logic               w_bad;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_wr_vld;
  rv_reg_t            w_wr_rd;
  logic [XLEN-1:0]    w_wr_val;
  reg_write_control_t w_wc_nxt;
  logic [31:0]        w_mask;

  // Load data extraction, extension and error classification
  always_comb begin
    w_byte = load_word[{load_addr_lo, 3'b000} +: 8];
    w_half = load_word[{load_addr_lo[1], 4'b0000} +: 16];
    w_ext  = '0;
    w_bad  = 1'b0;
    case (load_funct3)
      3'd0: w_ext = {{24{w_byte[7]}}, w_byte};
      3'd1: begin
        w_ext = {{16{w_half[15]}}, w_half};
        w_bad = load_addr_lo[0];
      end
      3'd2: begin
        w_ext = load_word;
        w_bad = (load_addr_lo != 2'd0);
      end
      3'd4: w_ext = {24'd0, w_byte};
      3'd5: begin
        w_ext = {16'd0, w_half};
        w_bad = load_addr_lo[0];
      end
      default: w_bad = 1'b1;
    endcase
  end

  // Handshake, FIFO push/pop and occupancy update
  always_comb begin
    w_accept    = load_valid & r_load_ready;
    w_push      = w_accept & ~w_bad;
    w_pop       = ~alu_wb_valid & (r_count != '0);
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Write port selection: ALU first, then FIFO head, else idle; x0 squashed
  always_comb begin
    w_wr_vld = 1'b0;
    w_wr_rd  = '0;
    w_wr_val = '0;
    if (alu_wb_valid) begin
      w_wr_vld = 1'b1;
      w_wr_rd  = alu_wb_rd;
      w_wr_val = alu_wb_value;
    end else if (w_pop) begin
      w_wr_vld = 1'b1;
      w_wr_rd  = r_ent_rd[r_head];
      w_wr_val = r_ent_val[r_head];
    end
    w_wc_nxt                = '0;
    w_wc_nxt.enable         = w_wr_vld & (w_wr_rd != '0);
    w_wc_nxt.which_register = w_wc_nxt.enable ? w_wr_rd : '0;
    w_wc_nxt.value          = w_wc_nxt.enable ? w_wr_val : '0;
  end

  // Pending-load mask decoded from the occupied FIFO entries
  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < LOAD_DEPTH; i++) begin
      if (r_ent_vld[PTR_W'(i)]) w_mask[r_ent_rd[PTR_W'(i)]] = 1'b1;
    end
    w_mask[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < LOAD_DEPTH; i++) begin
        r_ent_rd[PTR_W'(i)]  <= '0;
        r_ent_val[PTR_W'(i)] <= '0;
        r_ent_vld[PTR_W'(i)] <= 1'b0;
      end
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_wc         <= '0;
      r_load_ready <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_wc         <= w_wc_nxt;
      r_load_error <= w_accept & w_bad;
      r_load_ready <= (w_count_nxt < DEPTH_C);
      r_count      <= w_count_nxt;
      // head and tail only coincide when empty or full, so pop and push
      // never touch the same slot in one cycle
      if (w_pop) begin
        r_ent_vld[r_head] <= 1'b0;
        r_head            <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_ent_rd[r_tail]  <= load_rd;
        r_ent_val[r_tail] <= w_ext;
        r_ent_vld[r_tail] <= 1'b1;
        r_tail            <= r_tail + PTR_W'(1);
      end
    end
  end

  assign write_control = r_wc;
  assign load_ready    = r_load_ready;
  assign load_error    = r_load_error;
  assign pending_mask  = w_mask;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: constant vector table, directed multi-cycle
// sequences and randomized traffic against a queue-based reference model.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic               clock = 1'b0;
  logic               reset;
  logic               alu_wb_valid;
  rv_reg_t            alu_wb_rd;
  logic [31:0]        alu_wb_value;
  logic               load_valid;
  logic               load_ready;
  rv_reg_t            load_rd;
  logic [2:0]         load_funct3;
  logic [1:0]         load_addr_lo;
  logic [31:0]        load_word;
  reg_write_control_t write_control;
  logic [31:0]        pending_mask;
  logic               load_error;

  writeback_arbiter #(.LOAD_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_value(alu_wb_value),
    .load_valid(load_valid), .load_ready(load_ready), .load_rd(load_rd),
    .load_funct3(load_funct3), .load_addr_lo(load_addr_lo), .load_word(load_word),
    .write_control(write_control), .pending_mask(pending_mask), .load_error(load_error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } ent_t;

  ent_t q[$];      // loads the model believes are queued, oldest first
  bit   m_rdy;     // model view of load_ready for the current cycle

  typedef struct {
    bit          av;
    logic [4:0]  rd;
    logic [31:0] aval;
    logic [2:0]  f3;
    logic [1:0]  a;
    logic [31:0] w;
    bit          exp_en;
    logic [4:0]  exp_rd;
    logic [31:0] exp_val;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Load result from the ISA rules, using plain shifts and arithmetic
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w, output bit err);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    err = 1'b0;
    ref_load = 32'd0;
    case (f3)
      3'd0: ref_load = (b >= 128) ? b - 32'd256 : b;
      3'd1: begin err = (a % 2 != 0); ref_load = (h >= 32768) ? h - 32'd65536 : h; end
      3'd2: begin err = (a != 0); ref_load = w; end
      3'd4: ref_load = b;
      3'd5: begin err = (a % 2 != 0); ref_load = h; end
      default: err = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] mask_from_q();
    logic [31:0] m;
    m = 32'd0;
    foreach (q[i]) m[q[i].rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] aval,
                       input bit lv, input logic [4:0] lrd, input logic [2:0] f3,
                       input logic [1:0] a, input logic [31:0] w);
    alu_wb_valid = av;  alu_wb_rd = ard;  alu_wb_value = aval;
    load_valid = lv;    load_rd = lrd;    load_funct3 = f3;
    load_addr_lo = a;   load_word = w;
  endtask

  // One clock of stimulus, predicted by the model and checked after the edge
  task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] aval,
                       input bit lv, input logic [4:0] lrd, input logic [2:0] f3,
                       input logic [1:0] a, input logic [31:0] w);
    reg_write_control_t exp_wc;
    ent_t        e;
    bit          err;
    bit          acc;
    logic [31:0] v;
    drive(av, ard, aval, lv, lrd, f3, a, w);
    acc = lv && m_rdy;
    v = ref_load(f3, a, w, err);
    exp_wc = '0;
    if (av) begin
      if (ard != 0) exp_wc = {1'b1, ard, aval};
    end else if (q.size() > 0) begin
      e = q.pop_front();
      if (e.rd != 0) exp_wc = {1'b1, e.rd, e.val};
    end
    if (acc && !err) q.push_back('{lrd, v});
    @(posedge clock); #1;
    m_rdy = (q.size() < DEPTH);
    chk("write_control", 64'(write_control), 64'(exp_wc));
    chk("load_error", 64'(load_error), 64'(acc && err));
    chk("load_ready", 64'(load_ready), 64'(m_rdy));
    chk("pending_mask", 64'(pending_mask), 64'(mask_from_q()));
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1, 5'd5,  32'h1234,     3'd0, 2'd0, 32'h0,        1, 5'd5,  32'h1234,     0};
    vecs[1]  = '{1, 5'd0,  32'hDEAD,     3'd0, 2'd0, 32'h0,        0, 5'd0,  32'h0,        0};
    vecs[2]  = '{1, 5'd31, 32'hFFFFFFFF, 3'd0, 2'd0, 32'h0,        1, 5'd31, 32'hFFFFFFFF, 0};
    vecs[3]  = '{0, 5'd10, 32'h0,        3'd0, 2'd3, 32'h80FF7F01, 1, 5'd10, 32'hFFFFFF80, 0};
    vecs[4]  = '{0, 5'd11, 32'h0,        3'd4, 2'd1, 32'h80FF7F01, 1, 5'd11, 32'h0000007F, 0};
    vecs[5]  = '{0, 5'd12, 32'h0,        3'd1, 2'd2, 32'h80FF7F01, 1, 5'd12, 32'hFFFF80FF, 0};
    vecs[6]  = '{0, 5'd13, 32'h0,        3'd5, 2'd0, 32'h80FF7F01, 1, 5'd13, 32'h00007F01, 0};
    vecs[7]  = '{0, 5'd14, 32'h0,        3'd2, 2'd0, 32'h80FF7F01, 1, 5'd14, 32'h80FF7F01, 0};
    vecs[8]  = '{0, 5'd15, 32'h0,        3'd0, 2'd0, 32'h80FF7F01, 1, 5'd15, 32'h00000001, 0};
    vecs[9]  = '{0, 5'd16, 32'h0,        3'd4, 2'd2, 32'h80FF7F01, 1, 5'd16, 32'h000000FF, 0};
    vecs[10] = '{0, 5'd17, 32'h0,        3'd2, 2'd2, 32'h80FF7F01, 0, 5'd0,  32'h0,        1};
    vecs[11] = '{0, 5'd18, 32'h0,        3'd1, 2'd1, 32'h80FF7F01, 0, 5'd0,  32'h0,        1};
    vecs[12] = '{0, 5'd19, 32'h0,        3'd3, 2'd0, 32'h80FF7F01, 0, 5'd0,  32'h0,        1};
    vecs[13] = '{0, 5'd20, 32'h0,        3'd5, 2'd3, 32'h80FF7F01, 0, 5'd0,  32'h0,        1};
    vecs[14] = '{0, 5'd21, 32'h0,        3'd6, 2'd0, 32'h80FF7F01, 0, 5'd0,  32'h0,        1};
    vecs[15] = '{0, 5'd0,  32'h0,        3'd2, 2'd0, 32'h12345678, 0, 5'd0,  32'h0,        0};

    // Reset state, observed without any clock edge
    reset = 1'b0;
    m_rdy = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst write_control", 64'(write_control), 64'd0);
    chk("rst pending_mask", 64'(pending_mask), 64'd0);
    chk("rst load_ready", 64'(load_ready), 64'd0);
    chk("rst load_error", 64'(load_error), 64'd0);
    @(posedge clock); #3;
    reset = 1'b1;
    @(posedge clock); #1;
    m_rdy = 1'b1;
    chk("ready after release", 64'(load_ready), 64'd1);
    idle();

    // Table-driven single transactions starting from an empty FIFO
    for (int i = 0; i < 16; i++) begin
      logic [31:0]        pm;
      reg_write_control_t ew;
      ew = {vecs[i].exp_en, vecs[i].exp_rd, vecs[i].exp_val};
      pm = 32'd0;
      if (!vecs[i].av && !vecs[i].exp_err) pm[vecs[i].rd] = 1'b1;
      pm[0] = 1'b0;
      drive(vecs[i].av, vecs[i].rd, vecs[i].aval, !vecs[i].av, vecs[i].rd,
            vecs[i].f3, vecs[i].a, vecs[i].w);
      @(posedge clock); #1;
      chk($sformatf("vec%0d wc1", i), 64'(write_control), vecs[i].av ? 64'(ew) : 64'd0);
      chk($sformatf("vec%0d err", i), 64'(load_error), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d pend1", i), 64'(pending_mask), 64'(pm));
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clock); #1;
      chk($sformatf("vec%0d wc2", i), 64'(write_control), vecs[i].av ? 64'd0 : 64'(ew));
      chk($sformatf("vec%0d err2", i), 64'(load_error), 64'd0);
      chk($sformatf("vec%0d pend2", i), 64'(pending_mask), 64'd0);
      chk($sformatf("vec%0d ready", i), 64'(load_ready), 64'd1);
    end

    // Contention: ALU busy 4 cycles while loads to x7, x8, x9 are offered
    cycle(1, 5'd3, 32'h100, 1, 5'd7, 3'd2, 2'd0, 32'h70);
    chk("cont pend x7", 64'(pending_mask), 64'h80);
    cycle(1, 5'd4, 32'h101, 1, 5'd8, 3'd2, 2'd0, 32'h80);
    chk("cont pend x7x8", 64'(pending_mask), 64'h180);
    chk("cont full ready", 64'(load_ready), 64'd0);
    cycle(1, 5'd5, 32'h102, 1, 5'd9, 3'd2, 2'd0, 32'h90);
    chk("cont held pend", 64'(pending_mask), 64'h180);
    cycle(1, 5'd6, 32'h103, 1, 5'd9, 3'd2, 2'd0, 32'h90);
    cycle(0, 5'd0, 32'h0, 1, 5'd9, 3'd2, 2'd0, 32'h90);
    chk("cont x7 write", 64'(write_control), {26'd0, 1'b1, 5'd7, 32'h70});
    cycle(0, 5'd0, 32'h0, 1, 5'd9, 3'd2, 2'd0, 32'h90);
    chk("cont x8 write", 64'(write_control), {26'd0, 1'b1, 5'd8, 32'h80});
    chk("cont x9 pend", 64'(pending_mask), 64'h200);
    idle();
    chk("cont x9 write", 64'(write_control), {26'd0, 1'b1, 5'd9, 32'h90});
    idle();

    // Fill the FIFO, then stream 10 loads with no ALU traffic; pointers wrap
    cycle(1, 5'd1, 32'h1, 1, 5'd20, 3'd2, 2'd0, 32'hA0);
    cycle(1, 5'd2, 32'h2, 1, 5'd21, 3'd2, 2'd0, 32'hA1);
    for (int k = 1; k <= 10; k++)
      cycle(0, 0, 0, 1, 5'(k), 3'd2, 2'd0, 32'hB00 + 32'(k));
    for (int k = 0; k < 4; k++) idle();

    // Async reset with two entries queued
    cycle(1, 5'd1, 32'h5, 1, 5'd3, 3'd2, 2'd0, 32'hC3);
    cycle(1, 5'd2, 32'h6, 1, 5'd4, 3'd2, 2'd0, 32'hC4);
    chk("pre-reset pend", 64'(pending_mask), 64'h18);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("async rst wc", 64'(write_control), 64'd0);
    chk("async rst pend", 64'(pending_mask), 64'd0);
    chk("async rst ready", 64'(load_ready), 64'd0);
    q.delete();
    m_rdy = 1'b0;
    @(posedge clock); #3;
    reset = 1'b1;
    idle();
    idle();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 99) < 35, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 99) < 65, 5'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
    end
    for (int k = 0; k < 4; k++) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
